// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core: opcodes, FSM state codes, decoded-op struct.
// Optional halt-on-NUL behaviour is enabled with the BF_CORE_HALT_EN macro.
package bf_pkg;

    localparam int BF_ADDR_W  = 9;
    localparam int BF_DATA_W  = 8;
    localparam int BF_DEPTH_W = 8;

    localparam logic [BF_DATA_W-1:0] OP_INC   = 8'h2B;
    localparam logic [BF_DATA_W-1:0] OP_DEC   = 8'h2D;
    localparam logic [BF_DATA_W-1:0] OP_RIGHT = 8'h3E;
    localparam logic [BF_DATA_W-1:0] OP_LEFT  = 8'h3C;
    localparam logic [BF_DATA_W-1:0] OP_LOOP  = 8'h5B;
    localparam logic [BF_DATA_W-1:0] OP_END   = 8'h5D;
    localparam logic [BF_DATA_W-1:0] OP_OUT   = 8'h2E;
    localparam logic [BF_DATA_W-1:0] OP_IN    = 8'h2C;
    localparam logic [BF_DATA_W-1:0] OP_NUL   = 8'h00;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_EXEC   = 4'd1,
        ST_SFWD_F = 4'd2,
        ST_SFWD   = 4'd3,
        ST_SBWD_F = 4'd4,
        ST_SBWD   = 4'd5,
        ST_HALT   = 4'd6
    } bf_state_e;

    typedef struct packed {
        logic inc;
        logic dec;
        logic right;
        logic left;
        logic open;
        logic close;
        logic nul;
    } bf_op_t;

endpackage

// File: rtl/bf_if.sv
// Memory-side bundle of the core: code ROM port and tape RAM port.
interface bf_if #(
    parameter int ADDR_W = bf_pkg::BF_ADDR_W,
    parameter int DATA_W = bf_pkg::BF_DATA_W
);
    logic [ADDR_W-1:0] addr_code;
    logic [DATA_W-1:0] code_in;
    logic [ADDR_W-1:0] addr_array;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              write_rq;

    modport master (
        output addr_code, addr_array, data_out, write_rq,
        input  code_in, data_in
    );

    modport slave (
        input  addr_code, addr_array, data_out, write_rq,
        output code_in, data_in
    );
endinterface

// File: rtl/bf_decode.sv
// Opcode classifier: maps one code byte to a one-hot op vector; all-zero means no-op.
module bf_decode
    import bf_pkg::*;
(
    input  logic [BF_DATA_W-1:0] i_code,
    output bf_op_t               o_op
);

    // Classify the fetched byte
    always_comb begin
        o_op = '0;
        case (i_code)
            OP_INC:   o_op.inc   = 1'b1;
            OP_DEC:   o_op.dec   = 1'b1;
            OP_RIGHT: o_op.right = 1'b1;
            OP_LEFT:  o_op.left  = 1'b1;
            OP_LOOP:  o_op.open  = 1'b1;
            OP_END:   o_op.close = 1'b1;
            OP_NUL:   o_op.nul   = 1'b1;
            OP_OUT:   o_op       = '0;
            OP_IN:    o_op       = '0;
            default:  o_op       = '0;
        endcase
    end

endmodule

// File: rtl/brainfuck_core.sv
// Brainfuck interpreter core: fetch/execute FSM with bracket scanning over a synchronous code ROM.
// Define BF_CORE_HALT_EN to make a 0x00 opcode stop execution until reset.
module brainfuck_core
    import bf_pkg::*;
#(
    parameter int ADDR_W  = BF_ADDR_W,
    parameter int DATA_W  = BF_DATA_W,
    parameter int DEPTH_W = BF_DEPTH_W
) (
    input  logic       clk,
    input  logic       reset,
    bf_if.master       bus,
    output logic [3:0] probe
);

    localparam logic [ADDR_W-1:0]  PC_ONE    = ADDR_W'(1'b1);
    localparam logic [DATA_W-1:0]  DATA_ONE  = DATA_W'(1'b1);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1'b1);

    bf_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
    logic [DEPTH_W-1:0] r_depth, w_depth_nxt;
    logic [DATA_W-1:0]  w_data_out;
    logic               w_write_rq;
    logic               w_cell_zero;
    bf_op_t             w_op;

    bf_decode u_decode (
        .i_code (bus.code_in),
        .o_op   (w_op)
    );

    assign w_cell_zero = (bus.data_in == {DATA_W{1'b0}});

    // Next-state, register updates and RAM strobe
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ptr_nxt   = r_ptr;
        w_depth_nxt = r_depth;
        w_write_rq  = 1'b0;
        w_data_out  = bus.data_in;
        case (r_state)
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                w_pc_nxt    = r_pc + PC_ONE;
                if (w_op.inc) begin
                    w_write_rq = 1'b1;
                    w_data_out = bus.data_in + DATA_ONE;
                end else if (w_op.dec) begin
                    w_write_rq = 1'b1;
                    w_data_out = bus.data_in - DATA_ONE;
                end else if (w_op.right) begin
                    w_ptr_nxt = r_ptr + PC_ONE;
                end else if (w_op.left) begin
                    w_ptr_nxt = r_ptr - PC_ONE;
                end else if (w_op.open) begin
                    if (w_cell_zero) begin
                        w_depth_nxt = DEPTH_ONE;
                        w_state_nxt = ST_SFWD_F;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else if (w_op.close) begin
                    // Backward scan starts on the instruction just before the ']'
                    if (!w_cell_zero) begin
                        w_depth_nxt = DEPTH_ONE;
                        w_pc_nxt    = r_pc - PC_ONE;
                        w_state_nxt = ST_SBWD_F;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else if (w_op.nul) begin
`ifdef BF_CORE_HALT_EN
                    w_pc_nxt    = r_pc;
                    w_state_nxt = ST_HALT;
`else
                    w_state_nxt = ST_FETCH;
`endif
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_SFWD_F: w_state_nxt = ST_SFWD;
            ST_SFWD: begin
                if (w_op.open) begin
                    w_depth_nxt = r_depth + DEPTH_ONE;
                end else if (w_op.close) begin
                    w_depth_nxt = r_depth - DEPTH_ONE;
                end else begin
                    w_depth_nxt = r_depth;
                end
                w_pc_nxt = r_pc + PC_ONE;
                if (w_depth_nxt == {DEPTH_W{1'b0}}) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_SFWD_F;
                end
            end
            ST_SBWD_F: w_state_nxt = ST_SBWD;
            ST_SBWD: begin
                if (w_op.close) begin
                    w_depth_nxt = r_depth + DEPTH_ONE;
                end else if (w_op.open) begin
                    w_depth_nxt = r_depth - DEPTH_ONE;
                end else begin
                    w_depth_nxt = r_depth;
                end
                if (w_depth_nxt == {DEPTH_W{1'b0}}) begin
                    w_pc_nxt    = r_pc + PC_ONE;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_pc_nxt    = r_pc - PC_ONE;
                    w_state_nxt = ST_SBWD_F;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // State, PC, tape pointer and nesting depth registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
            r_pc    <= {ADDR_W{1'b0}};
            r_ptr   <= {ADDR_W{1'b0}};
            r_depth <= {DEPTH_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ptr   <= w_ptr_nxt;
            r_depth <= w_depth_nxt;
        end
    end

    assign bus.addr_code  = r_pc;
    assign bus.addr_array = r_ptr;
    assign bus.data_out   = w_data_out;
    assign bus.write_rq   = w_write_rq;
    assign probe          = r_state;

endmodule

// File: tb/tb_brainfuck_core.sv
// Bench for brainfuck_core: 16-entry registered ROM, 512x8 RAM, instruction-level reference interpreter.
module tb_brainfuck_core;
    import bf_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] probe;
    logic [7:0] rom [16];
    logic [7:0] ram [512];
    logic [7:0] code_reg;
    logic       seen [16];

    int n_checks;
    int n_errors;

    // Reference interpreter state
    int         m_pc;
    int         m_ptr;
    logic [7:0] m_tape [512];
    int         m_match [16];
    logic       m_halt;

    bf_if bus ();

    brainfuck_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .probe (probe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) code_reg <= rom[bus.addr_code[3:0]];
    assign bus.code_in = code_reg;
    assign bus.data_in = ram[bus.addr_array];

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
        end else if (bus.write_rq) begin
            ram[bus.addr_array] <= bus.data_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            seen[probe] = 1'b1;
        end
    endtask

    task automatic load_prog(input string s);
        for (int i = 0; i < 16; i++) rom[i] = (i < s.len()) ? s[i] : 8'h00;
    endtask

    task automatic model_reset();
        int stk [$];
        m_pc = 0;
        m_ptr = 0;
        m_halt = 1'b0;
        for (int i = 0; i < 512; i++) m_tape[i] = 8'h00;
        for (int i = 0; i < 16; i++) m_match[i] = -1;
        for (int i = 0; i < 16; i++) begin
            if (rom[i] == OP_LOOP) begin
                stk.push_back(i);
            end else if (rom[i] == OP_END && stk.size() > 0) begin
                int j;
                j = stk.pop_back();
                m_match[i] = i - (i - j);
                m_match[j] = i;
            end
        end
    endtask

    // One instruction of the reference interpreter; cyc = clock cycles it costs the core
    task automatic model_step(output int cyc);
        int idx;
        int d;
        logic [7:0] op;
        idx = m_pc % 16;
        op  = rom[idx];
        cyc = 2;
        if (!m_halt) begin
            case (op)
                OP_INC:   begin m_tape[m_ptr] = m_tape[m_ptr] + 8'd1; m_pc = (m_pc + 1) % 512; end
                OP_DEC:   begin m_tape[m_ptr] = m_tape[m_ptr] - 8'd1; m_pc = (m_pc + 1) % 512; end
                OP_RIGHT: begin m_ptr = (m_ptr + 1) % 512; m_pc = (m_pc + 1) % 512; end
                OP_LEFT:  begin m_ptr = (m_ptr + 511) % 512; m_pc = (m_pc + 1) % 512; end
                OP_LOOP: begin
                    if (m_tape[m_ptr] == 8'd0) begin
                        d = m_match[idx] - idx;
                        cyc = 2 + 2 * d;
                        m_pc = (m_pc + d + 1) % 512;
                    end else begin
                        m_pc = (m_pc + 1) % 512;
                    end
                end
                OP_END: begin
                    if (m_tape[m_ptr] != 8'd0) begin
                        d = idx - m_match[idx];
                        cyc = 2 + 2 * d;
                        m_pc = (m_pc - d + 1) % 512;
                    end else begin
                        m_pc = (m_pc + 1) % 512;
                    end
                end
`ifdef BF_CORE_HALT_EN
                OP_NUL:   m_halt = 1'b1;
`endif
                default:  m_pc = (m_pc + 1) % 512;
            endcase
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        model_reset();
    endtask

    task automatic check_boundary();
        chk("probe", 32'(probe), m_halt ? 32'd6 : 32'd0);
        chk("pc", 32'(bus.addr_code), m_pc);
        chk("ptr", 32'(bus.addr_array), m_ptr);
        chk("cell", 32'(ram[m_ptr]), 32'(m_tape[m_ptr]));
    endtask

    task automatic run_check(input int n_instr);
        int cyc;
        for (int i = 0; i < n_instr; i++) begin
            check_boundary();
            model_step(cyc);
            wait_cycles(cyc);
        end
        check_boundary();
    endtask

    // Random program with brackets balanced inside the 16-entry ROM, no NUL bytes
    task automatic gen_prog();
        int open_cnt;
        int rem;
        int r;
        open_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            rem = 16 - i;
            if (open_cnt == rem) begin
                rom[i] = OP_END;
                open_cnt--;
            end else begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2: rom[i] = OP_INC;
                    3:       rom[i] = OP_DEC;
                    4:       rom[i] = OP_RIGHT;
                    5:       rom[i] = OP_LEFT;
                    6: begin
                        if (open_cnt < rem - 1) begin rom[i] = OP_LOOP; open_cnt++; end
                        else rom[i] = OP_INC;
                    end
                    7: begin
                        if (open_cnt > 0) begin rom[i] = OP_END; open_cnt--; end
                        else rom[i] = OP_DEC;
                    end
                    8:       rom[i] = OP_OUT;
                    default: rom[i] = ($urandom_range(0, 1) == 0) ? OP_IN : 8'h41;
                endcase
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;

        load_prog("+++");
        do_reset();
        chk("rst_pc", 32'(bus.addr_code), 0);
        chk("rst_ptr", 32'(bus.addr_array), 0);
        chk("rst_probe", 32'(probe), 0);
        chk("rst_wrq", 32'(bus.write_rq), 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        for (int k = 1; k <= 8; k++) begin
            wait_cycles(1);
            chk("inc_wrq", 32'(bus.write_rq), (k == 1 || k == 3 || k == 5) ? 1 : 0);
            chk("inc_cell", 32'(ram[0]), (k / 2 > 3) ? 3 : k / 2);
        end

        load_prog(">>-<+");
        do_reset();
        run_check(5);
        chk("mv_cell2", 32'(ram[2]), 32'hFF);
        chk("mv_cell1", 32'(ram[1]), 32'h01);
        chk("mv_ptr", 32'(bus.addr_array), 1);

        load_prog("<");
        do_reset();
        run_check(1);
        chk("left_wrap", 32'(bus.addr_array), 511);

        load_prog("[+]>+");
        do_reset();
        run_check(3);
        chk("fwd_cell0", 32'(ram[0]), 0);
        chk("fwd_cell1", 32'(ram[1]), 1);
        chk("fwd_probe", 32'(seen[2] && seen[3]), 1);

        load_prog("++[->+<]");
        do_reset();
        run_check(8);
        chk("bwd_resume", 32'(bus.addr_code), 3);
        chk("bwd_probe", 32'(seen[4] && seen[5]), 1);
        run_check(5);
        chk("loop_cell0", 32'(ram[0]), 0);
        chk("loop_cell1", 32'(ram[1]), 2);

        load_prog("[[]]+");
        do_reset();
        run_check(1);
        chk("nest_pc", 32'(bus.addr_code), 4);
        run_check(1);
        chk("nest_cell", 32'(ram[0]), 1);

        load_prog("++[->+<]");
        do_reset();
        wait_cycles(20);
        chk("mid_scan", 32'((probe == 4'd4) || (probe == 4'd5)), 1);
        reset = 1'b0;
        wait_cycles(1);
        chk("abort_pc", 32'(bus.addr_code), 0);
        chk("abort_ptr", 32'(bus.addr_array), 0);
        chk("abort_probe", 32'(probe), 0);
        chk("abort_wrq", 32'(bus.write_rq), 0);
        reset = 1'b1;

`ifdef BF_CORE_HALT_EN
        load_prog("+");
        do_reset();
        run_check(3);
        chk("halt_probe", 32'(probe), 6);
        chk("halt_pc", 32'(bus.addr_code), 1);
        chk("halt_wrq", 32'(bus.write_rq), 0);
`endif

        for (int p = 0; p < 6; p++) begin
            gen_prog();
            do_reset();
            run_check(40);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
